// File: rtl/debounce_multi.sv
// debounce_multi: N-channel switch/push-button debouncer.
//
// Each channel runs independently through:
//   - a 2-flop synchroniser (btn_in -> s1 -> s2),
//   - a stability counter that flips the debounced level once s2 has differed
//     from it for STABLE_CYCLES consecutive edges,
//   - registered one-cycle rise/fall event pulses,
//   - an optional long-press detector.
//
// Optional feature macro: DEBOUNCE_LONG_PRESS_EN
//   defined   : per-channel hold counter, long_press[i] high once btn_db[i] has
//               been high for LONG_CYCLES edges.
//   undefined : no hold counters are built and long_press is tied to 0.
//
// Parameters:
//   NUM_CH        number of channels (>= 1)
//   STABLE_CYCLES edges of stable disagreement needed to flip a level (>= 2)
//   RST_VAL       debounced level of every channel after reset
//   LONG_CYCLES   hold time for long_press (> STABLE_CYCLES)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   btn_in     in   raw asynchronous inputs, bit i = channel i
//   btn_db     out  debounced levels
//   rise_pulse out  one-cycle pulse after btn_db[i] goes 0->1
//   fall_pulse out  one-cycle pulse after btn_db[i] goes 1->0
//   long_press out  high while channel has been debounced-high >= LONG_CYCLES

module debounce_multi #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned STABLE_CYCLES = 50000,
  parameter logic        RST_VAL       = 1'b0,
  parameter int unsigned LONG_CYCLES   = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] btn_in,
  output logic [NUM_CH-1:0] btn_db,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse,
  output logic [NUM_CH-1:0] long_press
);

  // Elaboration-time parameter sanity checks.
  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("debounce_multi: NUM_CH must be at least 1");
  end
  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("debounce_multi: STABLE_CYCLES must be at least 2");
  end
  if (LONG_CYCLES <= STABLE_CYCLES) begin : g_bad_long
    $error("debounce_multi: LONG_CYCLES must exceed STABLE_CYCLES");
  end

  localparam int unsigned     CntW   = $clog2(STABLE_CYCLES);
  // Terminal count: the flip happens on the edge that sees this value, so the
  // counter never needs to represent STABLE_CYCLES itself and cannot wrap.
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  // ---------------------------------------------------------------------------
  // Synchroniser: the only logic that looks at btn_in.
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0] s1_q;
  logic [NUM_CH-1:0] s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= {NUM_CH{RST_VAL}};
      s2_q <= {NUM_CH{RST_VAL}};
    end else begin
      s1_q <= btn_in;
      s2_q <= s1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stability counters and debounced levels.
  // ---------------------------------------------------------------------------
  logic [CntW-1:0]   cnt_q [NUM_CH];
  logic [CntW-1:0]   cnt_d [NUM_CH];
  logic [NUM_CH-1:0] db_q;
  logic [NUM_CH-1:0] db_d;
  logic [NUM_CH-1:0] flip;

  always_comb begin
    db_d = db_q;
    flip = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == db_q[i]) begin
        // Any return to the current level abandons the partial count.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        cnt_d[i] = '0;
        db_d[i]  = s2_q[i];
        flip[i]  = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CntOne;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q <= {NUM_CH{RST_VAL}};
      for (int i = 0; i < int'(NUM_CH); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      db_q <= db_d;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign btn_db = db_q;

  // ---------------------------------------------------------------------------
  // Event pulses: registered alongside the level, so a pulse is visible during
  // exactly the cycle in which the new level first appears. Reset forces both
  // low, so returning to RST_VAL through reset never produces an event.
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0] rise_q;
  logic [NUM_CH-1:0] fall_q;
  logic [NUM_CH-1:0] rise_d;
  logic [NUM_CH-1:0] fall_d;

  always_comb begin
    rise_d = flip & db_d;
    fall_d = flip & ~db_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

  // ---------------------------------------------------------------------------
  // Long-press detection.
  // ---------------------------------------------------------------------------
`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int unsigned      HoldW   = $clog2(LONG_CYCLES + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(LONG_CYCLES);
  localparam logic [HoldW-1:0] HoldOne = HoldW'(1);

  logic [HoldW-1:0]  hold_q [NUM_CH];
  logic [HoldW-1:0]  hold_d [NUM_CH];
  logic [NUM_CH-1:0] long_q;
  logic [NUM_CH-1:0] long_d;

  always_comb begin
    long_d = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (!db_q[i]) begin
        hold_d[i] = '0;
      end else if (hold_q[i] == HoldMax) begin
        // Saturate so a button held indefinitely keeps long_press asserted.
        hold_d[i] = hold_q[i];
      end else begin
        hold_d[i] = hold_q[i] + HoldOne;
      end
      // Registered from the next-state value so long_press tracks hold_q
      // exactly, without an extra cycle of lag.
      long_d[i] = (hold_d[i] == HoldMax);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      long_q <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      long_q <= long_d;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign long_press = long_q;
`else
  assign long_press = '0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Testbench for debounce_multi (NUM_CH=2, STABLE_CYCLES=4, RST_VAL=0,
// LONG_CYCLES=10). Directed table, hand-written corner sequences and random
// stimulus, all cross-checked against a window-based reference model.

module tb_debounce_multi;

  localparam int NumCh   = 2;
  localparam int Stable  = 4;
  localparam int LongCyc = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] btn_in = 2'b11;
  logic [1:0] btn_db;
  logic [1:0] rise_pulse;
  logic [1:0] fall_pulse;
  logic [1:0] long_press;

  debounce_multi #(
    .NUM_CH        (NumCh),
    .STABLE_CYCLES (Stable),
    .RST_VAL       (1'b0),
    .LONG_CYCLES   (LongCyc)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .btn_db     (btn_db),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .long_press (long_press)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam bit LongEn = 1'b1;
`else
  localparam bit LongEn = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Reference model. A level flips when the synchronised input (the raw sample
  // taken two edges earlier) has disagreed with it on each of the last Stable
  // edges, none of which precede the previous flip or reset.
  // ---------------------------------------------------------------------------
  logic [1:0] samp[$];       // samp[0] = raw input sampled at the previous edge
  int         e = 0;         // edge index
  int         last_flip[2];
  int         rise_edge[2];
  logic [1:0] m_db   = '0;
  logic [1:0] m_prev = '0;
  logic [1:0] m_rise = '0;
  logic [1:0] m_fall = '0;
  logic [1:0] m_long = '0;

  task automatic model_edge();
    logic [1:0] v;
    logic       ok;
    e++;
    m_prev = m_db;
    m_rise = '0;
    m_fall = '0;
    if (rst) begin
      m_db = '0;
      m_long = '0;
      last_flip[0] = e;
      last_flip[1] = e;
      samp.push_front(2'b00);
    end else begin
      for (int i = 0; i < NumCh; i++) begin
        ok = ((e - last_flip[i]) >= Stable);
        for (int k = 1; k <= Stable; k++) begin
          if (k >= samp.size()) begin
            ok = 1'b0;
          end else begin
            v = samp[k];
            if (v[i] == m_db[i]) ok = 1'b0;
          end
        end
        if (ok) begin
          m_db[i] = ~m_db[i];
          last_flip[i] = e;
          if (m_db[i]) begin
            m_rise[i] = 1'b1;
            rise_edge[i] = e;
          end else begin
            m_fall[i] = 1'b1;
          end
        end
        m_long[i] = LongEn && m_prev[i] && ((e - rise_edge[i]) >= LongCyc);
      end
      samp.push_front(btn_in);
    end
    if (samp.size() > Stable + 2) void'(samp.pop_back());
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  // Drive at the falling edge, clock once, sample at the next falling edge.
  task automatic step(input logic [1:0] b, input logic r);
    btn_in = b;
    rst    = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("model", {btn_db, rise_pulse, fall_pulse, long_press},
          {m_db, m_rise, m_fall, m_long});
  endtask

  // Reset must clear outputs immediately, without waiting for a clock edge.
  task automatic async_reset_check(input logic [1:0] b);
    btn_in = b;
    rst    = 1'b1;
    #1;
    check("async_rst", {btn_db, rise_pulse, fall_pulse, long_press}, 8'h00);
  endtask

  typedef struct {
    logic [1:0] btn;
    logic [1:0] db;
    logic [1:0] rise;
    logic [1:0] fall;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [1:0] b, input logic [1:0] d, input logic [1:0] r,
                     input logic [1:0] f, input int n);
    vec_t v;
    v.btn = b; v.db = d; v.rise = r; v.fall = f;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  initial begin
    logic [1:0] exp2;
    logic [1:0] b;
    logic       r;
    int         run[2];
    int         guard;

    // Clean press on ch0: flip on the 6th edge counting the first sample.
    add(2'b01, 2'b00, 2'b00, 2'b00, 5);
    add(2'b01, 2'b01, 2'b01, 2'b00, 1);
    add(2'b01, 2'b01, 2'b00, 2'b00, 1);
    // Clean press on ch1 while ch0 stays high.
    add(2'b11, 2'b01, 2'b00, 2'b00, 5);
    add(2'b11, 2'b11, 2'b10, 2'b00, 1);
    add(2'b11, 2'b11, 2'b00, 2'b00, 1);
    // Simultaneous release on both channels.
    add(2'b00, 2'b11, 2'b00, 2'b00, 5);
    add(2'b00, 2'b00, 2'b00, 2'b11, 1);
    add(2'b00, 2'b00, 2'b00, 2'b00, 1);
    // Bounce on ch0: high 3, low 1, high 3, low 1, then steady high.
    add(2'b01, 2'b00, 2'b00, 2'b00, 3);
    add(2'b00, 2'b00, 2'b00, 2'b00, 1);
    add(2'b01, 2'b00, 2'b00, 2'b00, 3);
    add(2'b00, 2'b00, 2'b00, 2'b00, 1);
    add(2'b01, 2'b00, 2'b00, 2'b00, 5);
    add(2'b01, 2'b01, 2'b01, 2'b00, 1);
    add(2'b01, 2'b01, 2'b00, 2'b00, 1);

    run[0] = 0;
    run[1] = 0;

    // Reset held 100 ns with both inputs high: everything stays low.
    for (int j = 0; j < 10; j++) begin
      step(2'b11, 1'b1);
      check("in_reset", {btn_db, rise_pulse, fall_pulse, long_press}, 8'h00);
    end
    // Release with inputs already high: normal step, full latency, pulse.
    for (int j = 1; j <= 7; j++) begin
      step(2'b11, 1'b0);
      exp2 = (j >= 6) ? 2'b11 : 2'b00;
      check("post_rst_db", {6'b0, btn_db}, {6'b0, exp2});
      exp2 = (j == 6) ? 2'b11 : 2'b00;
      check("post_rst_rise", {6'b0, rise_pulse}, {6'b0, exp2});
    end

    // Reset while both levels are high: no fall pulse.
    async_reset_check(2'b00);
    step(2'b00, 1'b1);
    check("rst_no_fall", {4'b0, btn_db, fall_pulse}, 8'h00);

    foreach (tbl[i]) begin
      step(tbl[i].btn, 1'b0);
      check("table", {2'b00, btn_db, rise_pulse, fall_pulse},
            {2'b00, tbl[i].db, tbl[i].rise, tbl[i].fall});
    end

    // Reset three edges into a count on ch0.
    for (int j = 0; j < 7; j++) step(2'b00, 1'b0);
    for (int j = 0; j < 3; j++) step(2'b01, 1'b0);
    async_reset_check(2'b01);
    step(2'b01, 1'b1);
    check("rst_mid", {2'b00, btn_db, rise_pulse, fall_pulse}, 8'h00);
    for (int j = 1; j <= 6; j++) begin
      step(2'b01, 1'b0);
      exp2 = (j == 6) ? 2'b01 : 2'b00;
      check("rst_mid_rise", {6'b0, rise_pulse}, {6'b0, exp2});
    end

    // Long press on ch1.
    guard = 0;
    step(2'b10, 1'b0);
    while (!btn_db[1] && guard < 20) begin
      step(2'b10, 1'b0);
      guard++;
    end
    check("long_rise_wait", {7'b0, btn_db[1]}, 8'd1);
    for (int j = 1; j <= LongCyc + 2; j++) begin
      step(2'b10, 1'b0);
      check("long_rise", {7'b0, long_press[1]}, {7'b0, LongEn && (j >= LongCyc)});
    end
    guard = 0;
    step(2'b00, 1'b0);
    while (btn_db[1] && guard < 20) begin
      step(2'b00, 1'b0);
      guard++;
    end
    check("long_fall_wait", {7'b0, btn_db[1]}, 8'd0);
    check("long_at_fall", {7'b0, long_press[1]}, {7'b0, LongEn});
    step(2'b00, 1'b0);
    check("long_after_fall", {7'b0, long_press[1]}, 8'd0);

    // Random runs of varying length, with occasional resets.
    b = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NumCh; i++) begin
        if (run[i] == 0) begin
          b[i]   = 1'($urandom_range(0, 1));
          run[i] = int'($urandom_range(1, 16));
        end
        run[i]--;
      end
      r = ($urandom_range(0, 299) == 0);
      step(b, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised N-channel successor to the single-input debounce block.
- Each channel has a 2-flop synchroniser, a stability counter, a debounced level output and one-cycle rise/fall event pulses.
- Sits between raw push-button/switch pins and control logic. The control logic includes the RDID command trigger, which consumes rise_pulse directly.
- Typical configuration: NUM_CH=4.

Parameters:
NUM_CH, 4, number of independent input channels (>=1)
STABLE_CYCLES, 50000, clock cycles a synchronised input must differ stably from the debounced level before the level flips (>=2)
RST_VAL, 1'b0, debounced level of every channel after reset; same value for all channels
LONG_CYCLES, 1000000, cycles a debounced high level must persist before long_press asserts; used only with the optional feature (>STABLE_CYCLES)

Ports:
clk  input  1  system clock; all logic is on the rising edge
rst  input  1  asynchronous, active-high reset
btn_in  input  NUM_CH  raw asynchronous inputs, bit i = channel i
btn_db  output  NUM_CH  debounced levels
rise_pulse  output  NUM_CH  one-cycle pulse when btn_db[i] goes 0->1
fall_pulse  output  NUM_CH  one-cycle pulse when btn_db[i] goes 1->0
long_press  output  NUM_CH  level; high while the channel has been debounced-high for >=LONG_CYCLES

Behaviour:
- Reset (async assert, released synchronously to clk by the system):
  - sync stages = RST_VAL; btn_db = RST_VAL replicated; counters = 0.
  - rise_pulse = 0, fall_pulse = 0, long_press = 0.
- Synchroniser:
  - btn_in[i] -> s1[i] -> s2[i], two flops per channel. No other logic reads btn_in.
- Stability counter: cnt[i], width $clog2(STABLE_CYCLES). On each edge:
  - if s2[i] == btn_db[i]: cnt <= 0.
  - else if cnt == STABLE_CYCLES-1: btn_db[i] <= s2[i]; cnt <= 0.
  - else: cnt <= cnt+1.
- Latency:
  - A clean input step first sampled at edge E appears on btn_db at edge E+1+STABLE_CYCLES.
  - That is, 2 sync edges plus STABLE_CYCLES counting edges, counting E as edge 1.
- Glitch rejection:
  - Any return of s2 to the btn_db level before the terminal count clears cnt to 0.
  - Partial counts never accumulate across glitches.
- Event pulses:
  - rise_pulse[i] / fall_pulse[i] are registered.
  - Each is high exactly for the one cycle after the edge at which btn_db[i] flips.
  - rise and fall on the same channel are never high together.
  - Minimum spacing between events on a channel is STABLE_CYCLES cycles.
- Channels are fully independent.
  - Simultaneous flips on several channels produce simultaneous pulses.
- Reset mid-count:
  - Counters are abandoned and btn_db returns to RST_VAL.
  - No pulse is generated by reset itself, including when btn_db was opposite RST_VAL.
- After reset release with btn_in already != RST_VAL:
  - Treated as a normal step; the flip occurs after the full latency and produces a pulse.
- Counter wrap: cannot occur, because the counter clears at its terminal value.

Optional Feature:
- Macro: DEBOUNCE_LONG_PRESS_EN.
- Defined:
  - Per-channel hold counter, width $clog2(LONG_CYCLES+1).
  - Cleared while btn_db[i]==0; increments while btn_db[i]==1; saturates at LONG_CYCLES.
  - long_press[i] is registered and equals (hold counter == LONG_CYCLES).
  - It rises LONG_CYCLES edges after btn_db[i] rises.
  - It falls on the edge after btn_db[i] falls.
  - Reset clears the hold counter and long_press.
- Undefined: no hold counters are built; long_press is tied to 0. The port list is unchanged.

Test Plan:
All scenarios use NUM_CH=2, STABLE_CYCLES=4, RST_VAL=0, LONG_CYCLES=10, 10 ns clock.
- Reset: assert rst for 100 ns with btn_in=2'b11 -> btn_db=00, all pulses 0, long_press=00 throughout reset, none during the first 5 edges after release.
- Clean press: ch0 steps 0->1, first sampled at edge E and held for 20 cycles -> btn_db[0]=1 at edge E+5; rise_pulse[0] high exactly one cycle; ch1 outputs unchanged.
- Bounce: ch0 high 3 cycles, low 1, high 3, low 1, then high steady -> no flip during the bounce; single rise_pulse[0] 5 edges after the final steady high is first sampled.
- Release and concurrency: both channels high-stable; drive both low on the same edge -> btn_db=00 on the same edge; fall_pulse=11 for one cycle; rise_pulse stays 00.
- Reset mid-operation: ch0 high 3 cycles into the count; pulse rst for 1 cycle -> btn_db[0]=0, no pulse. If btn_in is held high after release, rise occurs at the full 5-edge latency.
- Long press (DEBOUNCE_LONG_PRESS_EN defined): ch1 held high -> long_press[1]=1 exactly 10 edges after btn_db[1] rises; it drops the edge after btn_db[1] falls. Without the macro, long_press stays 00.
